// File: rtl/dram_bank_memory_if.sv
// Request/response bundle between the memory controller and the DRAM bank model,
// including the page hit/miss counters reported back upward.
interface dram_bank_memory_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_hit;
  logic [31:0]       page_hit_counter;
  logic [31:0]       page_miss_counter;

  modport master (
    output req_valid, req_addr, req_write, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_hit,
    input  page_hit_counter, page_miss_counter
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata,
    output req_ready, resp_valid, resp_data, resp_hit,
    output page_hit_counter, page_miss_counter
  );
endinterface

// File: rtl/dram_bank_memory.sv
// Multi-bank DRAM model with one open row per bank; responds HIT_LATENCY or MISS_LATENCY
// cycles after accept with a one-cycle pulse. One request in flight; req_ready only when idle.
module dram_bank_memory #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int COL_BITS     = 4,
  parameter int BANK_BITS    = 2,
  parameter int MEM_AW       = 10,
  parameter int HIT_LATENCY  = 4,
  parameter int MISS_LATENCY = 12
) (
  input  logic              clock,
  input  logic              reset,
  dram_bank_memory_if.slave bus
);
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int ROW_W     = ADDR_W - COL_BITS - BANK_BITS;
  localparam int MAX_LAT   = (MISS_LATENCY > HIT_LATENCY) ? MISS_LATENCY : HIT_LATENCY;
  localparam int LAT_W     = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [LAT_W-1:0]    r_lat;
  logic [LAT_W-1:0]    w_next_lat;
  logic [LAT_W-1:0]    w_init_lat;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_hit;
  logic [ROW_W-1:0]    r_open_row [NUM_BANKS];
  logic [NUM_BANKS-1:0] r_open_valid;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;
  logic [DATA_W-1:0]   r_mem [0:(1<<MEM_AW)-1];

  logic                w_accept;
  logic [BANK_BITS-1:0] w_bank;
  logic [ROW_W-1:0]    w_row;
  logic                w_hit_now;
  logic                w_respond;
  logic                w_commit;

  assign w_accept   = bus.req_valid && (r_state == IDLE) && !reset;
  assign w_bank     = bus.req_addr[COL_BITS +: BANK_BITS];
  assign w_row      = bus.req_addr[ADDR_W-1 -: ROW_W];
  assign w_hit_now  = r_open_valid[w_bank] && (r_open_row[w_bank] == w_row);
  assign w_init_lat = w_hit_now ? LAT_W'(HIT_LATENCY - 1) : LAT_W'(MISS_LATENCY - 1);
  // A reset landing in the RESPOND cycle suppresses both the pulse and the write commit.
  assign w_respond  = (r_state == RESPOND) && !reset;
  assign w_commit   = w_respond && r_write;

  always_comb begin
    w_next_state = r_state;
    w_next_lat   = r_lat;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_lat   = w_init_lat;
          w_next_state = (w_init_lat == '0) ? RESPOND : ACCESS;
        end
      end
      ACCESS: begin
        w_next_lat = r_lat - LAT_W'(1);
        if (r_lat <= LAT_W'(1)) begin
          w_next_state = RESPOND;
        end
      end
      RESPOND: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lat        <= '0;
      r_hit        <= 1'b0;
      r_write      <= 1'b0;
      r_open_valid <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_lat   <= w_next_lat;
      if (w_accept) begin
        r_hit   <= w_hit_now;
        r_write <= bus.req_write;
        if (w_hit_now) begin
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
          r_open_valid[w_bank] <= 1'b1;
        end
      end
    end
  end

  // Datapath latches need no reset: they are only observed after a fresh accept.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      if (!w_hit_now) r_open_row[w_bank] <= w_row;
    end
  end

  always_ff @(posedge clock) begin
    if (w_commit) r_mem[r_addr[MEM_AW-1:0]] <= r_wdata;
  end

  assign bus.req_ready         = (r_state == IDLE);
  assign bus.resp_valid        = w_respond;
  assign bus.resp_hit          = w_respond && r_hit;
  assign bus.resp_data         = (w_respond && !r_write) ? r_mem[r_addr[MEM_AW-1:0]] : '0;
  assign bus.page_hit_counter  = r_hit_cnt;
  assign bus.page_miss_counter = r_miss_cnt;
endmodule

// File: tb/tb_dram_bank_memory.sv
// Scenario-driven bench for dram_bank_memory: latency and handshake checked inline,
// response contents checked by a scoreboard monitor.
module tb_dram_bank_memory;
  logic clock;
  logic reset;

  dram_bank_memory_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dram_bank_memory dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        hit;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   resp_count = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.resp_valid === 1'b1) begin
      resp_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got data=%h hit=%b, none expected", bus.resp_data, bus.resp_hit);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.resp_hit !== mon_e.hit || (mon_e.chk && bus.resp_data !== mon_e.data)) begin
          errors++;
          $display("FAIL resp_contents: got data=%h hit=%b, expected data=%h hit=%b",
                   bus.resp_data, bus.resp_hit, mon_e.data, mon_e.hit);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    bus.req_write = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_hit, input bit chk,
                        input string name);
    int  n;
    int  k;
    int  lat;
    bit  got;
    lat = exp_hit ? 4 : 12;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_accept: req_ready never rose within 40 cycles", name);
      bus.req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{exp_d, exp_hit, chk});
    @(negedge clock);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_drop: req_ready=%b, expected 0", name, bus.req_ready);
    end
    k = 1;
    got = 0;
    while (k <= 20) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clock);
      k++;
    end
    checks++;
    if (!got || k != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0d), expected %0d", name, k, got, lat);
    end
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_resp: req_ready=%b resp_valid=%b, expected 1 and 0",
               name, bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 ||
        bus.resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h hit=%b, expected 1 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_hit);
    end
    checks++;
    if (bus.page_hit_counter !== 32'd0 || bus.page_miss_counter !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0 0",
               bus.page_hit_counter, bus.page_miss_counter);
    end
  endtask

  task automatic test_first_miss();
    access(32'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "first_miss");
    checks++;
    if (bus.page_hit_counter !== 32'd0 || bus.page_miss_counter !== 32'd1) begin
      errors++;
      $display("FAIL first_miss_counters: hit=%0d miss=%0d, expected 0 1",
               bus.page_hit_counter, bus.page_miss_counter);
    end
  endtask

  task automatic test_write_hit();
    do_reset();
    access(32'h15, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, "write_miss");
    access(32'h13, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "read_hit_13");
    access(32'h15, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, "read_hit_15");
    checks++;
    if (bus.page_hit_counter !== 32'd2 || bus.page_miss_counter !== 32'd1) begin
      errors++;
      $display("FAIL write_hit_counters: hit=%0d miss=%0d, expected 2 1",
               bus.page_hit_counter, bus.page_miss_counter);
    end
  endtask

  task automatic test_row_conflict();
    access(32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "conflict_55");
    access(32'h15, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "conflict_15");
    checks++;
    if (bus.page_hit_counter !== 32'd2 || bus.page_miss_counter !== 32'd3) begin
      errors++;
      $display("FAIL conflict_counters: hit=%0d miss=%0d, expected 2 3",
               bus.page_hit_counter, bus.page_miss_counter);
    end
  endtask

  task automatic test_bank_indep();
    logic [31:0] addrs [4];
    logic        hits  [4];
    addrs = '{32'h00, 32'h50, 32'h01, 32'h51};
    hits  = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      access(addrs[i], 1'b0, 32'h0, 32'h0, hits[i], 1'b0, "bank_indep");
    end
    checks++;
    if (bus.page_hit_counter !== 32'd2 || bus.page_miss_counter !== 32'd2) begin
      errors++;
      $display("FAIL bank_indep_counters: hit=%0d miss=%0d, expected 2 2",
               bus.page_hit_counter, bus.page_miss_counter);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int early;
    int rc0;
    int k;
    bit got;
    rc0 = resp_count;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h80;
    bus.req_write = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    early = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) bus.req_addr = 32'h90;
      if (bus.req_ready === 1'b1) early++;
      if (i < 12 && bus.resp_valid === 1'b1) early++;
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL hold_first: resp_valid=%b early_events=%0d, expected 1 and 0",
               bus.resp_valid, early);
    end
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_second_accept: req_ready=%b, expected 1", bus.req_ready);
    end
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    @(negedge clock);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_second_busy: req_ready=%b, expected 0", bus.req_ready);
    end
    k = 1;
    got = 0;
    while (k <= 20) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clock);
      k++;
    end
    checks++;
    if (!got || k != 12) begin
      errors++;
      $display("FAIL hold_second_latency: got %0d (seen=%0d), expected 12", k, got);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (resp_count - rc0 != 2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL hold_resp_count: got %0d responses, %0d pending, expected 2 and 0",
               resp_count - rc0, sb_q.size());
    end
  endtask

  task automatic test_reset_midop();
    int n;
    int seen;
    do_reset();
    access(32'h20, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, "prewrite_20");
    do_reset();
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h12345678;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.resp_valid === 1'b1) seen++;
      @(negedge clock);
    end
    checks++;
    if (seen != 0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_abort: resp pulses=%0d req_ready=%b, expected 0 and 1", seen, bus.req_ready);
    end
    checks++;
    if (bus.page_hit_counter !== 32'd0 || bus.page_miss_counter !== 32'd0) begin
      errors++;
      $display("FAIL midop_counters: hit=%0d miss=%0d, expected 0 0",
               bus.page_hit_counter, bus.page_miss_counter);
    end
    access(32'h00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "midop_read_00");
    checks++;
    if (bus.page_miss_counter !== 32'd1) begin
      errors++;
      $display("FAIL midop_miss_count: miss=%0d, expected 1", bus.page_miss_counter);
    end
    access(32'h20, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "midop_read_20");
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_first_miss();
    test_write_hit();
    test_row_conflict();
    test_bank_indep();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses missing, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_bank_memory.md
Name: dram_bank_memory

Overview:
- Memory-side stage that consumes the address stream issued by the memory controller.
- Models a multi-bank DRAM with one open row buffer per bank.
- Classifies each access as a page hit or a page miss, applies a hit or miss latency, and returns read data or a write acknowledgement with a one-cycle response pulse.
- Maintains the saturating page_hit_counter and page_miss_counter reported upward by the controller.

Parameters:
- ADDR_W, 32: request address width.
- DATA_W, 32: data width.
- COL_BITS, 4: column field, addr[3:0].
- BANK_BITS, 2: bank field, addr[5:4]; NUM_BANKS = 4.
- MEM_AW, 10: backing-store word address, addr[9:0], 1024 words.
- HIT_LATENCY, 4: cycles from accept to response on a hit; must be at least 1.
- MISS_LATENCY, 12: cycles from accept to response on a miss; must be at least 1.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept.
- req_addr  in  ADDR_W  byte-agnostic word address; row field is addr[31:6].
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  DATA_W  read data; 0 for writes.
- resp_hit  out  1  access was a page hit; qualified by resp_valid.
- page_hit_counter  out  32  saturating hit count.
- page_miss_counter  out  32  saturating miss count.

Behaviour:
- Reset state:
  - req_ready = 1; resp_valid = 0; resp_data = 0; resp_hit = 0.
  - Both counters = 0; all open_valid[b] = 0; FSM = IDLE.
  - Backing store is not cleared.
- FSM states: IDLE, ACCESS, RESPOND. req_ready = (state == IDLE), decoded combinationally.
- Accept: req_valid & req_ready at posedge T. Latch addr, write, wdata.
  - Hit: open_valid[bank] & (open_row[bank] == row). Set L = HIT_LATENCY; page_hit_counter += 1.
  - Miss: set L = MISS_LATENCY; page_miss_counter += 1; open_row[bank] <= row; open_valid[bank] <= 1.
  - Counter update is visible after edge T. Both counters saturate at 0xFFFFFFFF.
  - Go to ACCESS with latency counter = L-1. If L == 1, go directly to RESPOND.
- ACCESS: decrement counter each cycle; at 0, go to RESPOND.
- RESPOND cycle (cycle T+L after accept):
  - resp_valid = 1 for exactly one cycle; resp_hit = the latched classification.
  - Read: resp_data = mem[addr[9:0]].
  - Write: mem[addr[9:0]] <= wdata on this edge; resp_data = 0.
  - Next state is IDLE, so req_ready = 1 in cycle T+L+1.
  - No accept occurs in the RESPOND cycle.
- One outstanding request at a time. req_valid asserted while busy is ignored; the requester must hold it until req_ready.
- A read to the same address after a write returns the written data (the write commits at its response).
- Banks are independent: each tracks only its own open row.
- Reset mid-operation (any state):
  - Abort the access; no resp_valid.
  - Counters zero, all rows closed, IDLE on the next cycle.
  - An in-flight write is not committed.
- req_valid coincident with reset: not accepted.
- Address bits above the row field width are part of the row compare; no aliasing of rows.

Test Plan:
- Reset, then read 0x00 -> req_ready drops at T+1; resp_valid only at T+12; resp_hit = 0; miss = 1, hit = 0.
- Write 0x15 data 0xDEADBEEF (bank 1, row 0, miss, ack at T+12, resp_data = 0), then read 0x13 -> hit, resp at T+4; then read 0x15 -> hit, resp_data = 0xDEADBEEF; counters hit = 2, miss = 1.
- Row conflict: after the above, read 0x55 (bank 1, row 1) -> miss, 12 cycles; read 0x15 -> miss again, data 0xDEADBEEF; miss = 3.
- Bank independence: fresh reset, read 0x00 then 0x50 (2 misses), then 0x01 and 0x51 -> both hits, 4 cycles each; hit = 2, miss = 2.
- Busy hold: hold req_valid high with a new address during a miss -> exactly one accept; second accept on the cycle after resp_valid; no dropped or duplicate response.
- Reset at T+5 of a miss write to 0x20 with 0x12345678 -> no resp_valid, counters 0; read 0x00 -> miss; read 0x20 -> data not equal to 0x12345678 (bench pre-writes 0x0 to 0x20).
